// File: rtl/bus_pkg.sv
// Shared definitions for the daisy-chained register bus.
//   BUS_ADDR_WIDTH / BUS_DATA_WIDTH : default bus widths
//   state_e                         : bus_initiator FSM states
//   bus_txn_t                       : one bus beat {addr, wdata, rdata, rw, valid}
package bus_pkg;

  localparam int unsigned BUS_ADDR_WIDTH = 16;
  localparam int unsigned BUS_DATA_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  typedef struct packed {
    logic [BUS_ADDR_WIDTH-1:0] addr;
    logic [BUS_DATA_WIDTH-1:0] wdata;
    logic [BUS_DATA_WIDTH-1:0] rdata;
    logic                      rw;
    logic                      valid;
  } bus_txn_t;

endpackage

// File: rtl/bus_timeout_counter.sv
// Saturating wait counter for the bus initiator.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : restart the count at zero (priority over enable)
//   enable     : advance one step; holds at the last value, never wraps
//   expired    : count has reached TIMEOUT_CYCLES-1
module bus_timeout_counter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q != LAST)) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == LAST);

endmodule

// File: rtl/bus_initiator.sv
// Single-outstanding initiator for the daisy-chained register bus.
//   req_*   : host command port (valid/ready), one read or write at a time
//   resp_*  : one-cycle completion pulse with read data or timeout flag
//   stray_o : one-cycle pulse for any return that is not the expected one
//   *_o bus : chain head (valid_o strobes exactly one cycle per command)
//   *_i bus : chain tail, watched for the returning transaction
// All outputs are registered.
module bus_initiator
  import bus_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = BUS_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH     = BUS_DATA_WIDTH,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_rw_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  output logic                  resp_valid_o,
  output logic [DATA_WIDTH-1:0] resp_rdata_o,
  output logic                  resp_timeout_o,
  output logic                  stray_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [DATA_WIDTH-1:0] wdata_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  rw_o,
  output logic                  valid_o,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [DATA_WIDTH-1:0] rdata_i,
  input  logic                  rw_i,
  input  logic                  valid_i
);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  rw_q, rw_d;
  logic                  valid_q, valid_d;
  logic                  req_ready_q, req_ready_d;
  logic                  resp_valid_q, resp_valid_d;
  logic [DATA_WIDTH-1:0] resp_rdata_q, resp_rdata_d;
  logic                  resp_timeout_q, resp_timeout_d;
  logic                  stray_q, stray_d;

  logic match;
  logic cnt_clear;
  logic cnt_enable;
  logic cnt_expired;

  // Returning write data is not needed; the return is identified by addr/rw.
  logic unused_wdata;
  assign unused_wdata = ^wdata_i;

  assign match = valid_i && (addr_i == addr_q) && (rw_i == rw_q);

  bus_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (cnt_clear),
    .enable (cnt_enable),
    .expired(cnt_expired)
  );

  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    rw_d           = rw_q;
    valid_d        = 1'b0;
    req_ready_d    = req_ready_q;
    resp_valid_d   = 1'b0;
    resp_rdata_d   = resp_rdata_q;
    resp_timeout_d = resp_timeout_q;
    cnt_clear      = 1'b0;
    cnt_enable     = 1'b0;
    // Anything on the tail that is not the awaited return is flagged.
    stray_d        = valid_i && !((state_q == WAIT) && match);

    unique case (state_q)
      IDLE: begin
        // Ready comes up one edge after reset release, since it resets low.
        req_ready_d = 1'b1;
        if (req_valid_i && req_ready_q) begin
          addr_d      = req_addr_i;
          wdata_d     = req_wdata_i;
          rw_d        = req_rw_i;
          valid_d     = 1'b1;
          req_ready_d = 1'b0;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        cnt_clear = 1'b1;
        state_d   = WAIT;
      end
      WAIT: begin
        // Match is tested first so it wins over a simultaneous expiry.
        if (match) begin
          resp_rdata_d   = rdata_i;
          resp_timeout_d = 1'b0;
          resp_valid_d   = 1'b1;
          state_d        = RESP;
        end else if (cnt_expired) begin
          resp_rdata_d   = '0;
          resp_timeout_d = 1'b1;
          resp_valid_d   = 1'b1;
          state_d        = RESP;
        end else begin
          cnt_enable = 1'b1;
        end
      end
      RESP: begin
        req_ready_d = 1'b1;
        state_d     = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      addr_q         <= '0;
      wdata_q        <= '0;
      rw_q           <= 1'b0;
      valid_q        <= 1'b0;
      req_ready_q    <= 1'b0;
      resp_valid_q   <= 1'b0;
      resp_rdata_q   <= '0;
      resp_timeout_q <= 1'b0;
      stray_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      addr_q         <= addr_d;
      wdata_q        <= wdata_d;
      rw_q           <= rw_d;
      valid_q        <= valid_d;
      req_ready_q    <= req_ready_d;
      resp_valid_q   <= resp_valid_d;
      resp_rdata_q   <= resp_rdata_d;
      resp_timeout_q <= resp_timeout_d;
      stray_q        <= stray_d;
    end
  end

  assign req_ready_o    = req_ready_q;
  assign resp_valid_o   = resp_valid_q;
  assign resp_rdata_o   = resp_rdata_q;
  assign resp_timeout_o = resp_timeout_q;
  assign stray_o        = stray_q;
  assign addr_o         = addr_q;
  assign wdata_o        = wdata_q;
  assign rw_o           = rw_q;
  assign valid_o        = valid_q;
  assign rdata_o        = '0;

endmodule

// File: tb/tb_bus_initiator.sv
// Scoreboard bench for bus_initiator: the driver pushes expected issue beats
// and responses when a command is accepted; a monitor pops and compares on
// valid_o / resp_valid_o; a responder process models the chain.
module tb_bus_initiator;

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 16;
  localparam int unsigned TO = 8;

  logic          clk;
  logic          rst_n;
  logic          req_valid_i;
  logic          req_ready_o;
  logic          req_rw_i;
  logic [AW-1:0] req_addr_i;
  logic [DW-1:0] req_wdata_i;
  logic          resp_valid_o;
  logic [DW-1:0] resp_rdata_o;
  logic          resp_timeout_o;
  logic          stray_o;
  logic [AW-1:0] addr_o;
  logic [DW-1:0] wdata_o;
  logic [DW-1:0] rdata_o;
  logic          rw_o;
  logic          valid_o;
  logic [AW-1:0] addr_i;
  logic [DW-1:0] wdata_i;
  logic [DW-1:0] rdata_i;
  logic          rw_i;
  logic          valid_i;

  bus_initiator #(
    .ADDR_WIDTH    (AW),
    .DATA_WIDTH    (DW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid_i   (req_valid_i),
    .req_ready_o   (req_ready_o),
    .req_rw_i      (req_rw_i),
    .req_addr_i    (req_addr_i),
    .req_wdata_i   (req_wdata_i),
    .resp_valid_o  (resp_valid_o),
    .resp_rdata_o  (resp_rdata_o),
    .resp_timeout_o(resp_timeout_o),
    .stray_o       (stray_o),
    .addr_o        (addr_o),
    .wdata_o       (wdata_o),
    .rdata_o       (rdata_o),
    .rw_o          (rw_o),
    .valid_o       (valid_o),
    .addr_i        (addr_i),
    .wdata_i       (wdata_i),
    .rdata_i       (rdata_i),
    .rw_i          (rw_i),
    .valid_i       (valid_i)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          rw;
    int            cyc;
  } iss_t;

  typedef struct {
    logic [DW-1:0] rdata;
    logic          timeout;
    int            cyc;
  } rsp_t;

  typedef struct {
    int            lat;
    logic [DW-1:0] data;
    bit            silent;
    bit            stray;
  } cfg_t;

  iss_t iss_q[$];
  rsp_t rsp_q[$];
  cfg_t cfg_q[$];

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;
  int stray_seen = 0;
  int stray_exp  = 0;
  bit idle_stray_req = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compares issue beats and responses against the scoreboard.
  initial begin : monitor
    iss_t ie;
    rsp_t re;
    bit   ready_chk;
    ready_chk = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        ready_chk = 0;
      end else begin
        if (ready_chk) begin
          chk("ready_after_resp", 64'(req_ready_o), 64'(1));
          ready_chk = 0;
        end
        if (stray_o) stray_seen++;
        if (valid_o) begin
          if (iss_q.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL unexpected_issue: actual=valid_o addr 0x%0h required=no strobe (cycle %0d)", addr_o, cyc);
          end else begin
            ie = iss_q.pop_front();
            chk("issue_addr", 64'(addr_o), 64'(ie.addr));
            chk("issue_wdata", 64'(wdata_o), 64'(ie.wdata));
            chk("issue_rw", 64'(rw_o), 64'(ie.rw));
            chk("issue_cycle", 64'(cyc), 64'(ie.cyc));
          end
        end
        if (resp_valid_o) begin
          if (rsp_q.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL unexpected_resp: actual=resp_valid_o rdata 0x%0h required=no response (cycle %0d)", resp_rdata_o, cyc);
          end else begin
            re = rsp_q.pop_front();
            chk("resp_rdata", 64'(resp_rdata_o), 64'(re.rdata));
            chk("resp_timeout", 64'(resp_timeout_o), 64'(re.timeout));
            chk("resp_cycle", 64'(cyc), 64'(re.cyc));
          end
          ready_chk = 1;
        end
      end
    end
  end

  // Chain model: on each issue beat, returns after the configured latency.
  initial begin : responder
    cfg_t          c;
    logic [AW-1:0] a;
    logic [DW-1:0] w;
    logic          r;
    valid_i = 1'b0;
    addr_i  = '0;
    wdata_i = '0;
    rdata_i = '0;
    rw_i    = 1'b0;
    forever begin
      @(negedge clk);
      if (idle_stray_req) begin
        valid_i = 1'b1;
        addr_i  = 16'h0055;
        rw_i    = 1'b0;
        rdata_i = 16'h5555;
        @(negedge clk);
        valid_i = 1'b0;
        idle_stray_req = 0;
      end else if (valid_o && rst_n && cfg_q.size() != 0) begin
        c = cfg_q.pop_front();
        a = addr_o;
        w = wdata_o;
        r = rw_o;
        if (!c.silent) begin
          for (int i = 1; i <= c.lat; i++) begin
            @(negedge clk);
            if (i == c.lat) begin
              valid_i = 1'b1;
              addr_i  = a;
              rw_i    = r;
              wdata_i = w;
              rdata_i = c.data;
            end else if (c.stray && i == 1) begin
              valid_i = 1'b1;
              addr_i  = a ^ AW'(1);
              rw_i    = r;
              wdata_i = w;
              rdata_i = 16'hDEAD;
            end else begin
              valid_i = 1'b0;
            end
          end
          @(negedge clk);
          valid_i = 1'b0;
        end
      end
    end
  end

  task automatic send(input logic rw, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                      input int lat, input logic [DW-1:0] data, input bit silent,
                      input bit stray, input bit hold, output int acc);
    int   budget;
    cfg_t c;
    iss_t ie;
    rsp_t re;
    budget      = 0;
    acc         = -1;
    req_valid_i = 1'b1;
    req_rw_i    = rw;
    req_addr_i  = addr;
    req_wdata_i = wdata;
    while (!req_ready_o && budget < 100) begin
      @(negedge clk);
      budget++;
    end
    if (!req_ready_o) begin
      compared++;
      mismatched++;
      $display("FAIL accept_wait: actual=req_ready_o low for 100 cycles required=ready (addr 0x%0h)", addr);
      req_valid_i = 1'b0;
      return;
    end
    acc      = cyc + 1;
    ie.addr  = addr;
    ie.wdata = wdata;
    ie.rw    = rw;
    ie.cyc   = acc;
    iss_q.push_back(ie);
    c.lat    = lat;
    c.data   = data;
    c.silent = silent;
    c.stray  = stray;
    cfg_q.push_back(c);
    re.rdata   = silent ? '0 : data;
    re.timeout = silent;
    re.cyc     = silent ? acc + int'(TO) + 1 : acc + lat + 1;
    rsp_q.push_back(re);
    @(negedge clk);
    if (!hold) req_valid_i = 1'b0;
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    while (rsp_q.size() != 0 && budget < 100) begin
      @(negedge clk);
      budget++;
    end
    if (rsp_q.size() != 0) begin
      compared++;
      mismatched++;
      $display("FAIL resp_wait: actual=%0d responses missing required=0", rsp_q.size());
      rsp_q.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin : stimulus
    int acc;
    int a1;
    int a2;
    int a3;
    int budget;
    rst_n       = 1'b0;
    req_valid_i = 1'b0;
    req_rw_i    = 1'b0;
    req_addr_i  = '0;
    req_wdata_i = '0;

    repeat (3) @(negedge clk);
    chk("reset_ctrl", 64'({req_ready_o, resp_valid_o, resp_timeout_o, stray_o, valid_o, rw_o}), 64'(0));
    chk("reset_bus", 64'({addr_o, wdata_o}), 64'(0));
    chk("reset_rdata", 64'({resp_rdata_o, rdata_o}), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_release", 64'(req_ready_o), 64'(1));

    // Write, chain latency 2, echo returns wdata as rdata.
    send(1'b1, 16'h0003, 16'h0001, 2, 16'h0001, 0, 0, 0, acc);
    drain();

    // Read, latency 1: minimum 3-cycle command-to-response.
    send(1'b0, 16'h0010, 16'h0000, 1, 16'hBEEF, 0, 0, 0, acc);
    drain();

    // Silent chain: timeout after TO+2 cycles, rdata forced to 0.
    send(1'b0, 16'h0020, 16'h0000, 0, 16'h0000, 1, 0, 0, acc);
    drain();

    // Mismatched return (addr 0x0011) first, the real one at latency 3.
    stray_exp++;
    send(1'b0, 16'h0010, 16'h0000, 3, 16'h1234, 0, 1, 0, acc);
    drain();
    chk("stray_count_wait", 64'(stray_seen), 64'(stray_exp));

    // Return while idle: stray only, no response.
    stray_exp++;
    idle_stray_req = 1;
    budget = 0;
    while (idle_stray_req && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    repeat (3) @(negedge clk);
    chk("stray_count_idle", 64'(stray_seen), 64'(stray_exp));

    // Three reads with req_valid_i held high; each waits for ready.
    send(1'b0, 16'h0100, 16'h0000, 1, 16'h00A1, 0, 0, 1, a1);
    send(1'b0, 16'h0101, 16'h0000, 2, 16'h00A2, 0, 0, 1, a2);
    send(1'b0, 16'h0102, 16'h0000, 1, 16'h00A3, 0, 0, 0, a3);
    chk("b2b_gap_1", 64'(a2 - a1), 64'(1 + 3));
    chk("b2b_gap_2", 64'(a3 - a2), 64'(2 + 3));
    drain();

    // Reset between edges while waiting on a silent chain.
    send(1'b0, 16'h0040, 16'h7777, 0, 16'h0000, 1, 0, 0, acc);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_ctrl", 64'({req_ready_o, resp_valid_o, resp_timeout_o, stray_o, valid_o, rw_o}), 64'(0));
    chk("midreset_bus", 64'({addr_o, wdata_o}), 64'(0));
    chk("midreset_rdata", 64'({resp_rdata_o, rdata_o}), 64'(0));
    rsp_q.delete();
    repeat (2) @(negedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_midreset", 64'(req_ready_o), 64'(1));
    send(1'b0, 16'h0030, 16'h0000, 2, 16'hC0DE, 0, 0, 0, acc);
    drain();
    repeat (TO + 4) @(negedge clk);
    chk("stray_count_final", 64'(stray_seen), 64'(stray_exp));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: actual=simulation still running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
